// File: rtl/bitstream_output_buffer.sv
// Byte FIFO behind the entropy encoder: accepts 0-3 bytes per cycle and drains them one per cycle over valid/ready.
// Tags the frame's final byte, and reports fill level, dropped groups, reserved flags and frame completion.
module bitstream_output_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 5,
    parameter int AF_MARGIN  = 4
) (
    input  logic                  top_clk,
    input  logic                  top_reset,
    input  logic [DATA_WIDTH-1:0] in_bit_1,
    input  logic [DATA_WIDTH-1:0] in_bit_2,
    input  logic [DATA_WIDTH-1:0] in_last_bit,
    input  logic [1:0]            in_flag_bitstream,
    input  logic                  in_flag_last,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [DEPTH_LOG2:0]   out_count,
    output logic                  out_almost_full,
    output logic                  out_overflow,
    output logic                  out_error,
    output logic                  out_done
);
    // state   | meaning
    // S_RUN   | accepting write groups until the end-of-frame flag
    // S_DRAIN | inputs ignored, emptying the FIFO
    // S_DONE  | frame fully drained, held until reset
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   mem_byte [DEPTH];
    logic                    mem_tag  [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]           count, count_next, free_slots;
    logic                    overflow_q, error_q;
    logic [1:0]              n_bytes;
    logic [DATA_WIDTH-1:0]   w_byte [3];
    logic [2:0]              w_tag;
    logic                    inputs_live, accept, wr_en, rd_fire;

    // Pack the group so slot k always goes to wr_ptr+k; last_bit lands right after the flagged bytes.
    always_comb begin
        w_byte[0] = in_bit_1;
        w_byte[1] = in_bit_2;
        w_byte[2] = in_last_bit;
        w_tag     = '0;
        n_bytes   = 2'd0;
        case (in_flag_bitstream)
            2'b01: begin
                n_bytes   = 2'd1;
                w_byte[1] = in_last_bit;
                w_tag[1]  = in_flag_last;
            end
            2'b10: begin
                n_bytes   = 2'd2;
                w_tag[2]  = in_flag_last;
            end
            default: begin
                w_byte[0] = in_last_bit;
                w_tag[0]  = in_flag_last;
            end
        endcase
        if (in_flag_last) n_bytes = n_bytes + 2'd1;
    end

    assign free_slots = CW'(DEPTH) - count;
    assign accept     = free_slots >= CW'(n_bytes);
    assign wr_en      = inputs_live && accept && (n_bytes != 2'd0);
    assign rd_fire    = out_valid && out_ready;
    assign count_next = count + (wr_en ? CW'(n_bytes) : CW'(0)) - CW'(rd_fire);

    always_ff @(posedge top_clk) begin
        if (top_reset) state <= S_RUN;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_RUN:   if (in_flag_last) state_next = S_DRAIN;
            S_DRAIN: if (count_next == '0) state_next = S_DONE;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_RUN;
        endcase
    end

    always_comb begin
        inputs_live = (state == S_RUN);
        out_done    = (state == S_DONE);
        out_valid   = (count != '0) && (state != S_DONE);
    end

    always_ff @(posedge top_clk) begin
        if (top_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            if (wr_en)   wr_ptr <= wr_ptr + DEPTH_LOG2'(n_bytes);
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            if (inputs_live && !accept)                 overflow_q <= 1'b1;
            if (inputs_live && in_flag_bitstream == 2'b11) error_q <= 1'b1;
        end
    end

    // Storage is deliberately left uncleared by reset; pointers and count define what is valid.
    always_ff @(posedge top_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (wr_en && (k < int'(n_bytes))) begin
                mem_byte[wr_ptr + DEPTH_LOG2'(k)] <= w_byte[k];
                mem_tag[wr_ptr + DEPTH_LOG2'(k)]  <= w_tag[k];
            end
        end
    end

    assign out_data        = out_valid ? mem_byte[rd_ptr] : '0;
    assign out_last        = out_valid && mem_tag[rd_ptr];
    assign out_count       = count;
    assign out_almost_full = count >= CW'(DEPTH - AF_MARGIN);
    assign out_overflow    = overflow_q;
    assign out_error       = error_q;
endmodule

// File: tb/tb_bitstream_output_buffer.sv
// Directed bench for bitstream_output_buffer: ordering, frame end, full/overflow, wrap, reserved flag, mid-frame reset.
module tb_bitstream_output_buffer;
    logic       top_clk = 1'b0;
    logic       top_reset;
    logic [7:0] in_bit_1, in_bit_2, in_last_bit;
    logic [1:0] in_flag_bitstream;
    logic       in_flag_last;
    logic [7:0] out_data;
    logic       out_valid, out_ready, out_last;
    logic [5:0] out_count;
    logic       out_almost_full, out_overflow, out_error, out_done;

    int checks = 0;
    int errors = 0;

    bitstream_output_buffer #(.DATA_WIDTH(8), .DEPTH_LOG2(5), .AF_MARGIN(4)) dut (
        .top_clk(top_clk), .top_reset(top_reset),
        .in_bit_1(in_bit_1), .in_bit_2(in_bit_2), .in_last_bit(in_last_bit),
        .in_flag_bitstream(in_flag_bitstream), .in_flag_last(in_flag_last),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_count(out_count), .out_almost_full(out_almost_full),
        .out_overflow(out_overflow), .out_error(out_error), .out_done(out_done)
    );

    always #5 top_clk = ~top_clk;

    task automatic step();
        @(posedge top_clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_bit_1 = 8'h00; in_bit_2 = 8'h00; in_last_bit = 8'h00;
        in_flag_bitstream = 2'b00; in_flag_last = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        top_reset = 1'b1;
        step();
        top_reset = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", out_data); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
        checks++; if (out_count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d want 0", out_count); end
        checks++; if (out_almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b want 0", out_almost_full); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", out_overflow); end
        checks++; if (out_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", out_error); end
        checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", out_done); end
    endtask

    task automatic test_basic_order();
        do_reset();
        out_ready = 1'b1;
        in_flag_bitstream = 2'b10; in_bit_1 = 8'hA1; in_bit_2 = 8'hB2;
        step();
        idle_inputs();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin errors++; $display("FAIL basic_first got v=%b d=%h want v=1 d=a1", out_valid, out_data); end
        checks++; if (out_count !== 6'd2) begin errors++; $display("FAIL basic_count2 got %0d want 2", out_count); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hB2) begin errors++; $display("FAIL basic_second got v=%b d=%h want v=1 d=b2", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_count !== 6'd0) begin errors++; $display("FAIL basic_empty got v=%b d=%h c=%0d want 0/00/0", out_valid, out_data, out_count); end
        checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL basic_not_done got %b want 0", out_done); end
    endtask

    task automatic test_final_group();
        do_reset();
        out_ready = 1'b1;
        in_flag_bitstream = 2'b01; in_bit_1 = 8'h11; in_last_bit = 8'h7F; in_flag_last = 1'b1;
        step();
        in_flag_bitstream = 2'b10; in_bit_1 = 8'hE1; in_bit_2 = 8'hE2; in_flag_last = 1'b0;
        checks++; if (out_data !== 8'h11 || out_last !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL final_first got d=%h l=%b v=%b want 11/0/1", out_data, out_last, out_valid); end
        step();
        checks++; if (out_data !== 8'h7F || out_last !== 1'b1 || out_done !== 1'b0) begin errors++; $display("FAIL final_last got d=%h l=%b done=%b want 7f/1/0", out_data, out_last, out_done); end
        step();
        checks++; if (out_done !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL final_done got done=%b v=%b d=%h want 1/0/00", out_done, out_valid, out_data); end
        in_flag_last = 1'b1; in_last_bit = 8'h99;
        step(); step();
        idle_inputs();
        checks++; if (out_count !== 6'd0 || out_valid !== 1'b0 || out_done !== 1'b1) begin errors++; $display("FAIL final_ignore got c=%0d v=%b done=%b want 0/0/1", out_count, out_valid, out_done); end
    endtask

    task automatic test_full_overflow();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_flag_bitstream = 2'b10; in_bit_1 = 8'(2*i); in_bit_2 = 8'(2*i+1);
            step();
            checks++; if (out_count !== 6'(2*(i+1)) || out_almost_full !== (2*(i+1) >= 28)) begin
                errors++; $display("FAIL full_fill[%0d] got c=%0d af=%b want c=%0d af=%b", i, out_count, out_almost_full, 2*(i+1), (2*(i+1) >= 28));
            end
        end
        in_flag_bitstream = 2'b01; in_bit_1 = 8'hEE;
        step();
        idle_inputs();
        checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL full_ovf got %b want 1", out_overflow); end
        checks++; if (out_count !== 6'd32 || out_data !== 8'h00) begin errors++; $display("FAIL full_hold got c=%0d d=%h want 32/00", out_count, out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 8'(i)) begin errors++; $display("FAIL full_drain[%0d] got v=%b d=%h want 1/%h", i, out_valid, out_data, 8'(i)); end
            step();
        end
        checks++; if (out_valid !== 1'b0 || out_count !== 6'd0 || out_overflow !== 1'b1) begin errors++; $display("FAIL full_end got v=%b c=%0d ovf=%b want 0/0/1", out_valid, out_count, out_overflow); end
    endtask

    task automatic test_wrap();
        int pushed, popped, cycles;
        logic push, fire;
        do_reset();
        pushed = 0; popped = 0; cycles = 0;
        while (popped < 45 && cycles < 600) begin
            checks++; if (out_count !== 6'(pushed - popped) || out_valid !== (pushed > popped)) begin
                errors++; $display("FAIL wrap_level cyc %0d got c=%0d v=%b want c=%0d", cycles, out_count, out_valid, pushed - popped);
            end
            out_ready = 1'($urandom_range(0, 1));
            push = (pushed < 45) && (pushed - popped < 28) && ($urandom_range(0, 3) != 0);
            idle_inputs();
            if (push) begin in_flag_bitstream = 2'b01; in_bit_1 = 8'(pushed); end
            fire = (pushed > popped) && out_ready;
            if (fire) begin
                checks++; if (out_data !== 8'(popped)) begin errors++; $display("FAIL wrap_data got %h want %h", out_data, 8'(popped)); end
            end
            step();
            if (fire) popped++;
            if (push) pushed++;
            cycles++;
        end
        idle_inputs();
        checks++; if (popped != 45) begin errors++; $display("FAIL wrap_timeout got %0d bytes want 45", popped); end
        checks++; if (out_count !== 6'd0 || out_overflow !== 1'b0) begin errors++; $display("FAIL wrap_end got c=%0d ovf=%b want 0/0", out_count, out_overflow); end
    endtask

    task automatic test_reserved();
        do_reset();
        out_ready = 1'b0;
        in_flag_bitstream = 2'b11; in_flag_last = 1'b1;
        in_bit_1 = 8'hAA; in_bit_2 = 8'hBB; in_last_bit = 8'h55;
        step();
        idle_inputs();
        checks++; if (out_error !== 1'b1) begin errors++; $display("FAIL rsv_err got %b want 1", out_error); end
        checks++; if (out_count !== 6'd1 || out_data !== 8'h55 || out_last !== 1'b1) begin errors++; $display("FAIL rsv_store got c=%0d d=%h l=%b want 1/55/1", out_count, out_data, out_last); end
        out_ready = 1'b1;
        step();
        checks++; if (out_done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rsv_done got done=%b v=%b want 1/0", out_done, out_valid); end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        out_ready = 1'b0;
        in_flag_bitstream = 2'b11;
        step();
        checks++; if (out_error !== 1'b1 || out_count !== 6'd0) begin errors++; $display("FAIL mid_rsv got err=%b c=%0d want 1/0", out_error, out_count); end
        for (int i = 0; i < 5; i++) begin
            in_flag_bitstream = 2'b10; in_bit_1 = 8'(8'h40 + i); in_bit_2 = 8'(8'h50 + i);
            step();
        end
        idle_inputs();
        checks++; if (out_count !== 6'd10 || out_data !== 8'h40) begin errors++; $display("FAIL mid_fill got c=%0d d=%h want 10/40", out_count, out_data); end
        do_reset();
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || out_count !== 6'd0) begin
            errors++; $display("FAIL mid_reset_data got v=%b d=%h l=%b c=%0d want 0/00/0/0", out_valid, out_data, out_last, out_count);
        end
        checks++; if (out_almost_full !== 1'b0 || out_overflow !== 1'b0 || out_error !== 1'b0 || out_done !== 1'b0) begin
            errors++; $display("FAIL mid_reset_flags got af=%b ovf=%b err=%b done=%b want 0000", out_almost_full, out_overflow, out_error, out_done);
        end
        in_flag_bitstream = 2'b01; in_bit_1 = 8'h3C;
        step();
        idle_inputs();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_count !== 6'd1) begin errors++; $display("FAIL mid_next got v=%b d=%h c=%0d want 1/3c/1", out_valid, out_data, out_count); end
    endtask

    initial begin
        top_reset = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_basic_order();
        test_final_group();
        test_full_overflow();
        test_wrap();
        test_reserved();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bitstream_output_buffer.md
# bitstream_output_buffer

Byte-stream output buffer placed directly downstream of `entropy_encoder`. Each cycle it accepts 0–3 bytes from the encoder's carry-propagation outputs (`OUT_BIT_1`, `OUT_BIT_2`, `OUT_LAST_BIT`, `OUT_FLAG_BITSTREAM`, `OUT_FLAG_LAST`) and stores them in order in a circular FIFO. It drains the FIFO one byte per cycle over a valid/ready interface, tags the final byte of the frame, and reports fill level and overflow, because the encoder cannot be stalled.

## Interface
Parameters:
- `DATA_WIDTH`, 8: byte width; must equal the encoder's `TOP_BITSTREAM_WIDTH`.
- `DEPTH_LOG2`, 5: FIFO depth = 2^DEPTH_LOG2 entries (32).
- `AF_MARGIN`, 4: `out_almost_full` asserts when free entries ≤ AF_MARGIN.

Ports:
- `top_clk`  in  1  sole clock, rising edge.
- `top_reset`  in  1  synchronous, active-high reset.
- `in_bit_1`  in  DATA_WIDTH  first byte (from `OUT_BIT_1`).
- `in_bit_2`  in  DATA_WIDTH  second byte (from `OUT_BIT_2`).
- `in_last_bit`  in  DATA_WIDTH  held final byte (from `OUT_LAST_BIT`).
- `in_flag_bitstream`  in  2  encoding: 00 none, 01 `in_bit_1` only, 10 `in_bit_1` then `in_bit_2`, 11 reserved.
- `in_flag_last`  in  1  end of frame; `in_last_bit` is appended after the flagged bytes.
- `out_data`  out  DATA_WIDTH  head byte; 0 when `out_valid`=0.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` when `out_valid` && `out_ready`.
- `out_last`  out  1  head byte is the frame's final byte (qualified by `out_valid`).
- `out_count`  out  DEPTH_LOG2+1  current occupancy.
- `out_almost_full`  out  1  count ≥ 2^DEPTH_LOG2 − AF_MARGIN.
- `out_overflow`  out  1  sticky: a write group was dropped.
- `out_error`  out  1  sticky: reserved flag 11 was received.
- `out_done`  out  1  frame fully drained; held until reset.

## Operation
- **Storage.** Register array of 2^DEPTH_LOG2 entries, each {last_tag, byte}. Write and read pointers are DEPTH_LOG2 bits wide and wrap modulo depth. The count register is tracked separately.
- **Write group size.** n = (flag==01 ? 1 : flag==10 ? 2 : 0) + (in_flag_last ? 1 : 0), giving 0..3 bytes. Bytes are written in order bit_1, bit_2, last_bit to wr_ptr, wr_ptr+1, wr_ptr+2 (mod depth). Only the last_bit entry carries last_tag=1.
- **Write acceptance.** A group is accepted iff (depth − count) ≥ n, using the count value before this cycle's read. A group is never partially written. A rejected group sets `out_overflow` and leaves the FIFO and pointers unchanged.
- **Reserved flag.** Flag 11 writes no bytes and sets `out_error`. If `in_flag_last` is set in the same cycle, last_bit is still written.
- **Read.** On a read fire, rd_ptr increments.
- **Count update.** count_next = count + (accepted ? n : 0) − read_fire. Simultaneous read and write is legal in every state, including a full FIFO with n=0.
- **State machine** (state register, reset to RUN):
  - RUN: writes allowed. When `in_flag_last`=1, go to DRAIN, whether the group is accepted or dropped.
  - DRAIN: all inputs ignored, no writes. Go to DONE on the cycle count_next==0.
  - DONE: inputs ignored; `out_done`=1; `out_valid`=0. Exit only by reset.
- **Reset.** `top_reset`, including mid-frame, clears pointers, count, state (to RUN) and all sticky flags in the same edge. Array contents are not cleared.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `out_count`=0, `out_almost_full`=0, `out_overflow`=0, `out_error`=0, `out_done`=0.
- Write latency: a group presented in cycle N is visible at the head (`out_valid`=1, `out_data`=bit_1) from cycle N+1 if the FIFO was empty. There is no combinational input-to-output path.
- `out_data`, `out_last` and `out_valid` come from registered state only: the count and pointers plus an array read mux.
- `out_count`, `out_almost_full`, `out_overflow`, `out_error` and `out_done` update one cycle after the causing event.
- Sustained throughput: 1 byte/cycle out; up to 3 bytes/cycle in. The encoder side relies on `out_almost_full` to avoid loss.
- Handshake: `out_data` and `out_last` must stay stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- **Basic ordering.** After reset, present flag=10, bit_1=0xA1, bit_2=0xB2 with `out_ready`=1 → cycle+1: out_data=0xA1; cycle+2: 0xB2; then `out_valid`=0, count=0.
- **Final group.** flag=01, bit_1=0x11, last_bit=0x7F, `in_flag_last`=1 → bytes 0x11 then 0x7F with `out_last`=1 on 0x7F only. `out_done`=1 the cycle after 0x7F fires; later inputs are ignored.
- **Full and overflow.** Hold `out_ready`=0 and feed flag=10 for 16 cycles → count=32 and almost_full=1 (asserted from count 28). A 17th flag=01 group is dropped, `out_overflow`=1, count stays 32, and the head byte is unchanged.
- **Wrap-around.** Push and pop 45 sequential bytes (0x00..0x2C) with random `out_ready` → output is exactly 0x00..0x2C in order with no loss.
- **Reserved flag.** Apply flag=11 with `in_flag_last`=1, last_bit=0x55 → `out_error`=1 and only 0x55 is stored, tagged last.
- **Reset mid-frame.** With count=10, assert `top_reset` one cycle → next cycle all outputs are at reset values. A new flag=01 byte 0x3C is the next output byte.
